bm_ibuf_fetch: RTL and testbench

Read-DMA front end for the block-matching input line buffer. It fetches image lines from external memory through an AXI4 read master (address and data channels only) and writes them into the LR line buffer as a 32-bit word stream. Flow control uses the buffer's `wr_rdy`. A `line_end` pulse accompanies the final word of every line. The block sits directly upstream of the LR input buffer, one instance per camera.

---
 rtl/bm_pkg.sv | 30 +++
 rtl/bm_fetch_agen.sv | 90 +++++++++
 rtl/bm_ibuf_fetch.sv | 186 ++++++++++++++++++
 tb/tb_bm_ibuf_fetch.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// bm_pkg: shared types and constants for the block-matching fetch path.
// FSM states, AXI response code and the legal burst lengths.
package bm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } fetch_st_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [8:0] BST_LEN_64  = 9'd64;
  localparam logic [8:0] BST_LEN_128 = 9'd128;
  localparam logic [8:0] BST_LEN_256 = 9'd256;

  // Unsupported burst lengths fall back to the smallest legal one.
  function automatic logic [8:0] bst_legal(logic [8:0] b);
    logic [8:0] r;
    unique case (1'b1)
      (b == BST_LEN_128): r = BST_LEN_128;
      (b == BST_LEN_256): r = BST_LEN_256;
      default:            r = BST_LEN_64;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bm_fetch_agen.sv
// bm_fetch_agen: line/offset address generator for the input fetch.
// Stride is accumulated per line; burst length = min(bst, words left).
module bm_fetch_agen
  import bm_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic [15:0]   stride_i,
  input  logic [8:0]    line_size_i,
  input  logic [10:0]   num_lines_i,
  input  logic [8:0]    bst_len_i,
  input  logic          advance_i,
  output logic [AW-1:0] addr_o,
  output logic [8:0]    len_o,
  output logic          line_done_o,
  output logic          last_line_o
);

  logic [AW-1:0] base_q, base_d;
  logic [15:0]   stride_q, stride_d;
  logic [8:0]    lsize_q, lsize_d;
  logic [10:0]   nlines_q, nlines_d;
  logic [8:0]    bst_q, bst_d;
  logic [10:0]   line_q, line_d;
  logic [8:0]    ofs_q, ofs_d;

  logic [8:0]    rem;
  logic [9:0]    ofs_sum;

  assign rem         = lsize_q - ofs_q;
  assign len_o       = (bst_q < rem) ? bst_q : rem;
  assign ofs_sum     = {1'b0, ofs_q} + {1'b0, len_o};
  assign line_done_o = (ofs_sum == {1'b0, lsize_q});
  assign last_line_o = (line_q == nlines_q - 11'd1);
  assign addr_o      = base_q + AW'({ofs_q, 2'b00});

  // Next-state: latch frame setup on load, step offset/line per burst.
  always_comb begin
    base_d   = base_q;
    stride_d = stride_q;
    lsize_d  = lsize_q;
    nlines_d = nlines_q;
    bst_d    = bst_q;
    line_d   = line_q;
    ofs_d    = ofs_q;
    if (load_i) begin
      base_d   = base_i;
      stride_d = stride_i;
      lsize_d  = line_size_i;
      nlines_d = num_lines_i;
      bst_d    = bst_legal(bst_len_i);
      line_d   = '0;
      ofs_d    = '0;
    end else if (advance_i) begin
      if (line_done_o) begin
        line_d = line_q + 11'd1;
        ofs_d  = '0;
        base_d = base_q + AW'(stride_q);
      end else begin
        ofs_d  = ofs_sum[8:0];
      end
    end
  end

  // Generator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      stride_q <= '0;
      lsize_q  <= '0;
      nlines_q <= '0;
      bst_q    <= '0;
      line_q   <= '0;
      ofs_q    <= '0;
    end else begin
      base_q   <= base_d;
      stride_q <= stride_d;
      lsize_q  <= lsize_d;
      nlines_q <= nlines_d;
      bst_q    <= bst_d;
      line_q   <= line_d;
      ofs_q    <= ofs_d;
    end
  end

endmodule

// File: rtl/bm_ibuf_fetch.sv
// bm_ibuf_fetch: AXI4 read-DMA front end for the LR input line buffer.
// Optional BM_FETCH_RRESP_CHK_EN enables the sticky err flag.
module bm_ibuf_fetch
  import bm_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   stride,
  input  logic [8:0]    line_size,
  input  logic [10:0]   num_lines,
  input  logic [8:0]    bst_len,
  input  logic          wr_rdy,
  output logic          wr,
  output logic [31:0]   din,
  output logic          line_end,
  output logic [AW-1:0] m_araddr,
  output logic [7:0]    m_arlen,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic [31:0]   m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rlast,
  input  logic          m_rvalid,
  output logic          m_rready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  fetch_st_e     st_q;
  logic          wr_q;
  logic [31:0]   din_q;
  logic          le_q;
  logic [AW-1:0] araddr_q;
  logic [7:0]    arlen_q;
  logic          arvalid_q;
  logic          rready_q;
  logic          busy_q;
  logic          done_q;

  logic          load;
  logic          beat;
  logic          bst_end;
  logic [AW-1:0] ag_addr;
  logic [8:0]    ag_len;
  logic          ag_line_done;
  logic          ag_last_line;

  assign load    = (st_q == ST_IDLE) && start;
  assign beat    = rready_q && m_rvalid;
  assign bst_end = beat && m_rlast;

  bm_fetch_agen #(
    .AW(AW)
  ) u_agen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .base_i     (base_addr),
    .stride_i   (stride),
    .line_size_i(line_size),
    .num_lines_i(num_lines),
    .bst_len_i  (bst_len),
    .advance_i  (bst_end),
    .addr_o     (ag_addr),
    .len_o      (ag_len),
    .line_done_o(ag_line_done),
    .last_line_o(ag_last_line)
  );

  // Frame FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      wr_q      <= 1'b0;
      din_q     <= '0;
      le_q      <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      le_q   <= 1'b0;
      done_q <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            st_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wr_rdy) begin
            araddr_q  <= ag_addr;
            arlen_q   <= 8'(ag_len - 9'd1);
            arvalid_q <= 1'b1;
            st_q      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            st_q      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            wr_q  <= 1'b1;
            din_q <= m_rdata;
            le_q  <= m_rlast && ag_line_done;
          end
          if (bst_end) begin
            rready_q <= 1'b0;
            if (ag_line_done && ag_last_line) begin
              st_q <= ST_DONE;
            end else begin
              st_q <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          st_q   <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign wr        = wr_q;
  assign din       = din_q;
  assign line_end  = le_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef BM_FETCH_RRESP_CHK_EN
  logic [8:0] bcnt_q;
  logic       err_q;
  logic       cnt_hit;
  logic       bad_beat;

  assign cnt_hit  = (bcnt_q == ag_len - 9'd1);
  assign bad_beat = beat &&
                    ((m_rresp != RESP_OKAY) ||
                     (m_rlast != cnt_hit));

  // Beat counter and sticky error (bad resp or rlast mismatch).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (load) begin
        err_q <= 1'b0;
      end else if (bad_beat) begin
        err_q <= 1'b1;
      end
      if (st_q == ST_ADDR) begin
        bcnt_q <= '0;
      end else if (beat) begin
        bcnt_q <= bcnt_q + 9'd1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^(m_rresp ^ RESP_OKAY);
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bm_ibuf_fetch.sv
// tb_bm_ibuf_fetch: random AXI slave + word-stream reference model.
// Expected bursts/words are derived from frame geometry directly.
module tb_bm_ibuf_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] stride;
  logic [8:0]  line_size;
  logic [10:0] num_lines;
  logic [8:0]  bst_len;
  logic        wr_rdy;
  logic        wr;
  logic [31:0] din;
  logic        line_end;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  bm_ibuf_fetch #(.AW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .stride   (stride),
    .line_size(line_size),
    .num_lines(num_lines),
    .bst_len  (bst_len),
    .wr_rdy   (wr_rdy),
    .wr       (wr),
    .din      (din),
    .line_end (line_end),
    .m_araddr (m_araddr),
    .m_arlen  (m_arlen),
    .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata  (m_rdata),
    .m_rresp  (m_rresp),
    .m_rlast  (m_rlast),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

`ifdef BM_FETCH_RRESP_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // reference model outputs
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  logic [31:0] exp_data[$];
  bit          exp_le[$];

  task automatic build_model(logic [31:0] b, logic [15:0] s,
                             int ls, int nl, int bst);
    logic [31:0] lb;
    int n;
    exp_addr.delete();
    exp_len.delete();
    exp_data.delete();
    exp_le.delete();
    for (int l = 0; l < nl; l++) begin
      lb = b + 32'(l) * {16'h0, s};
      for (int o = 0; o < ls; o += bst) begin
        n = (ls - o < bst) ? ls - o : bst;
        exp_addr.push_back(lb + 32'(4 * o));
        exp_len.push_back(n);
      end
      for (int w = 0; w < ls; w++) begin
        exp_data.push_back(mem_word(lb + 32'(4 * w)));
        exp_le.push_back(w == ls - 1);
      end
    end
  endtask

  // slave knobs and state
  int          ar_pct = 100;
  int          r_gap  = 0;
  int          slverr_beat = -1;
  int          beat_idx;
  logic [31:0] pend_addr[$];
  int          pend_len[$];
  logic [31:0] cur_addr;
  int          beats_left = 0;
  bit          r_hold = 0;
  bit          ar_wait = 0;
  logic [39:0] ar_prev;

  // AXI slave: inputs change on negedge only
  initial begin
    m_arready = 0;
    m_rvalid  = 0;
    m_rlast   = 0;
    m_rdata   = 0;
    m_rresp   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_arready = 0;
        m_rvalid  = 0;
        m_rlast   = 0;
        m_rresp   = 0;
        pend_addr.delete();
        pend_len.delete();
        beats_left = 0;
        r_hold  = 0;
        ar_wait = 0;
      end else begin
        if (beats_left == 0 && pend_len.size() > 0) begin
          cur_addr   = pend_addr.pop_front();
          beats_left = pend_len.pop_front();
        end
        if (!r_hold) begin
          if (beats_left > 0 &&
              $urandom_range(99) >= r_gap) begin
            m_rvalid = 1;
            m_rdata  = mem_word(cur_addr);
            m_rlast  = (beats_left == 1);
            m_rresp  = (beat_idx == slverr_beat) ?
                       2'b10 : 2'b00;
          end else begin
            m_rvalid = 0;
            m_rlast  = 0;
            m_rresp  = 0;
          end
        end
        if (m_rvalid && m_rready) begin
          r_hold = 0;
          cur_addr += 4;
          beats_left--;
          beat_idx++;
        end else begin
          r_hold = m_rvalid;
        end
        if (ar_wait) begin
          chk("ar_stable", {m_arvalid, m_araddr, m_arlen},
              {1'b1, ar_prev});
        end
        m_arready = ($urandom_range(99) < ar_pct);
        if (m_arvalid && m_arready) begin
          ar_wait = 0;
          if (exp_addr.size() == 0) begin
            chk("ar_extra", 1, 0);
          end else begin
            chk("araddr", m_araddr, exp_addr.pop_front());
            chk("arlen", m_arlen, exp_len.pop_front() - 1);
          end
          pend_addr.push_back(m_araddr);
          pend_len.push_back(int'(m_arlen) + 1);
        end else begin
          ar_wait = m_arvalid;
          ar_prev = {m_araddr, m_arlen};
        end
      end
    end
  end

  // write-side monitor
  int wr_cnt;
  int done_cnt;
  bit expect_done = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (expect_done) begin
          chk("done_after_last", done, 1);
          expect_done = 0;
        end
        if (wr) begin
          wr_cnt++;
          if (exp_data.size() == 0) begin
            chk("wr_extra", 1, 0);
          end else begin
            chk("din", din, exp_data.pop_front());
            chk("line_end", line_end, exp_le.pop_front());
            if (exp_data.size() == 0) expect_done = 1;
          end
        end
        if (done) begin
          done_cnt++;
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  // wr_rdy: random mode, or a 50-cycle stall after line 0
  bit rdy_rand = 0;
  bit stall_en = 0;
  int stall_av;

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_rand) wr_rdy = ($urandom_range(3) != 0);
      if (stall_en && rst_n && wr && line_end) begin
        stall_en = 0;
        wr_rdy   = 0;
        stall_av = 0;
        repeat (50) begin
          @(negedge clk);
          if (m_arvalid) stall_av++;
        end
        chk("stall_no_arvalid", stall_av, 0);
        wr_rdy = 1;
        @(negedge clk);
        chk("resume_arvalid", m_arvalid, 1);
      end
    end
  end

  task automatic chk_reset_outs(string tag);
    chk({tag, "_ctl"},
        {wr, line_end, m_arvalid, m_rready, busy, done, err},
        7'd0);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_ar"}, {m_araddr, m_arlen}, 40'd0);
  endtask

  task automatic run_frame(logic [31:0] b, logic [15:0] s,
                           int ls, int nl, int bst,
                           bit lat_chk, bit exp_err,
                           int abort_at);
    int c;
    base_addr = b;
    stride    = s;
    line_size = 9'(ls);
    num_lines = 11'(nl);
    bst_len   = 9'(bst);
    build_model(b, s, ls, nl, bst);
    wr_cnt = 0;
    done_cnt = 0;
    beat_idx = 0;
    expect_done = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_t1", busy, 1);
    chk("err_clr", err, 0);
    if (lat_chk) begin
      chk("arvalid_t1", m_arvalid, 0);
      @(negedge clk);
      chk("arvalid_t2", m_arvalid, 1);
    end
    if (abort_at >= 0) begin
      c = 0;
      while (wr_cnt < abort_at && c < 20000) begin
        @(negedge clk);
        c++;
      end
      chk("abort_reach", wr_cnt >= abort_at, 1);
      rst_n = 0;
      #1;
      chk_reset_outs("rst_mid");
      repeat (3) @(negedge clk);
      chk_reset_outs("rst_hold");
      rst_n = 1;
      expect_done = 0;
      @(negedge clk);
      return;
    end
    c = 0;
    while (done_cnt == 0 && c < 40000) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    chk("done_cnt", done_cnt, 1);
    chk("wr_cnt", wr_cnt, ls * nl);
    chk("bursts_left", exp_addr.size(), 0);
    chk("busy_end", busy, 0);
    chk("err_end", err, exp_err);
  endtask

  initial begin
    logic [31:0] rb;
    int rls;
    int rnl;
    int rbst;
    int rst_k;
    #800000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rb;
    int rls;
    int rnl;
    int rbst;
    int sk;
    rst_n = 0;
    start = 0;
    wr_rdy = 1;
    base_addr = 0;
    stride = 0;
    line_size = 0;
    num_lines = 0;
    bst_len = 0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1;
    repeat (2) @(negedge clk);

    run_frame(32'h1000_0000, 16'h0400, 64, 4, 64, 1, 0, -1);
    run_frame(32'h2000_0000, 16'h0800, 320, 2, 128, 1, 0, -1);

    stall_en = 1;
    run_frame(32'h3000_0400, 16'h0400, 64, 3, 64, 1, 0, -1);
    stall_en = 0;

    ar_pct = 60;
    r_gap = 30;
    rdy_rand = 1;
    for (int i = 0; i < 5; i++) begin
      rls  = $urandom_range(1, 300);
      rnl  = $urandom_range(1, 4);
      sk   = $urandom_range(2);
      rbst = (sk == 0) ? 64 : (sk == 1) ? 128 : 256;
      rb   = $urandom();
      rb[9:0] = '0;
      sk = (4 * rls + 1023) / 1024 + $urandom_range(2);
      run_frame(rb, 16'(sk * 1024), rls, rnl, rbst,
                0, 0, -1);
    end
    rdy_rand = 0;
    wr_rdy = 1;

    slverr_beat = 37;
    run_frame(32'h1000_0000, 16'h0400, 64, 4, 64,
              1, ERR_EN, -1);
    slverr_beat = -1;

    run_frame(32'h2000_0000, 16'h0800, 320, 2, 128,
              1, 0, 100);
    run_frame(32'h2000_0000, 16'h0800, 320, 2, 128,
              1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
